// File: rtl/irq_ctrl_pkg.sv
// Shared register-map and FSM-state constants for the interrupt controller.
package irq_ctrl_pkg;

  localparam logic [1:0] IRQ_PENDING = 2'd0;
  localparam logic [1:0] IRQ_ENABLE  = 2'd1;
  localparam logic [1:0] IRQ_STATUS  = 2'd2;
  localparam logic [1:0] IRQ_EOI     = 2'd3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  function automatic logic [31:0] status_word(input logic [1:0] st, input logic [4:0] vec);
    return {st, 25'b0, vec};
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: SYNC_STAGES-deep synchroniser followed by a rising-edge detector.
// rise is combinational from the last sync stage, so a captured edge lands in pending SYNC_STAGES edges later.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic irq_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = irq_in;
    prev_d    = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: edge-latched pending bits, enable mask,
// lowest-index priority and a single in-service interrupt closed by EOI.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NIRQ        = 32,
  parameter int SYNC_STAGES = 2,
  parameter int VW          = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NIRQ-1:0] irqs,
  input  logic            strobe,
  input  logic            rw,
  input  logic [1:0]      addr,
  input  logic [31:0]     d_in,
  output logic [31:0]     d_out,
  output logic            irq_req,
  output logic [VW-1:0]   irq_vec,
  input  logic            irq_ack
);

  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] pending_q, pending_d;
  logic [NIRQ-1:0] enable_q, enable_d;
  logic [1:0]      state_q, state_d;
  logic [VW-1:0]   irq_vec_q, irq_vec_d;
  logic [31:0]     d_out_q, d_out_d;

  logic [NIRQ-1:0] cand, w1c, ack_clr;
  logic            cand_vld, ack_fire, wr, rd, still_posted;
  logic [VW-1:0]   cand_vec;

  for (genvar i = 0; i < NIRQ; i++) begin : g_line
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .irq_in  (irqs[i]),
      .rise    (rise[i])
    );
  end

  assign wr       = strobe & rw;
  assign rd       = strobe & ~rw;
  assign cand     = pending_q & enable_q;
  assign ack_fire = (state_q == ST_REQ) & irq_ack;

  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    cand_vld = 1'b0;
    cand_vec = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        cand_vld = 1'b1;
        cand_vec = VW'(i);
      end
    end
  end

  // New edges are OR-ed in after the clears so a same-cycle set always wins.
  always_comb begin
    w1c     = '0;
    ack_clr = '0;
    for (int i = 0; i < NIRQ; i++) begin
      ack_clr[i] = ack_fire && (irq_vec_q == VW'(i));
    end
    if (wr && addr == IRQ_PENDING) begin
      w1c = d_in[NIRQ-1:0];
    end
    pending_d = (pending_q & ~(w1c | ack_clr)) | rise;
    enable_d  = (wr && addr == IRQ_ENABLE) ? d_in[NIRQ-1:0] : enable_q;
  end

  // Withdrawal looks at next-cycle pending/enable so irq_req drops right after the offending write.
  assign still_posted = pending_d[irq_vec_q] & enable_d[irq_vec_q];

  always_comb begin
    state_d   = state_q;
    irq_vec_d = irq_vec_q;
    case (state_q)
      ST_IDLE: begin
        if (cand_vld) begin
          state_d   = ST_REQ;
          irq_vec_d = cand_vec;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_d = ST_SERVICE;
        end else if (!still_posted) begin
          state_d   = ST_IDLE;
          irq_vec_d = '0;
        end
      end
      ST_SERVICE: begin
        if (wr && addr == IRQ_EOI) begin
          state_d   = ST_IDLE;
          irq_vec_d = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        irq_vec_d = '0;
      end
    endcase
  end

  always_comb begin
    d_out_d = d_out_q;
    if (rd) begin
      case (addr)
        IRQ_PENDING: d_out_d = 32'(pending_q);
        IRQ_ENABLE:  d_out_d = 32'(enable_q);
        IRQ_STATUS:  d_out_d = status_word(state_q, 5'(irq_vec_q));
        default:     d_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      enable_q  <= '0;
      state_q   <= ST_IDLE;
      irq_vec_q <= '0;
      d_out_q   <= '0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      state_q   <= state_d;
      irq_vec_q <= irq_vec_d;
      d_out_q   <= d_out_d;
    end
  end

  assign irq_req = (state_q == ST_REQ);
  assign irq_vec = irq_vec_q;
  assign d_out   = d_out_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed walk through the register map and FSM, then random traffic against a reference model.
module tb_irq_ctrl;

  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] irqs = '0;
  logic        strobe = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] d_in = '0;
  logic [31:0] d_out;
  logic        irq_req;
  logic [4:0]  irq_vec;
  logic        irq_ack = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.NIRQ(32), .SYNC_STAGES(SS), .VW(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irqs    (irqs),
    .strobe  (strobe),
    .rw      (rw),
    .addr    (addr),
    .d_in    (d_in),
    .d_out   (d_out),
    .irq_req (irq_req),
    .irq_vec (irq_vec),
    .irq_ack (irq_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: line history kept as a plain array of past samples;
  // a pending bit appears SS edges after a 0->1 sample.
  logic [31:0] m_samp [0:SS+1];
  logic [31:0] m_pend, m_en, m_dout;
  int          m_st;
  int          m_vec;

  always @(posedge clk or negedge reset_n) begin : model
    logic [31:0] cand, rise, w1c, ackm, npend, nen;
    int lo;
    if (!reset_n) begin
      for (int j = 0; j <= SS + 1; j++) m_samp[j] = '0;
      m_pend = '0; m_en = '0; m_dout = '0; m_st = 0; m_vec = 0;
    end else begin
      cand = m_pend & m_en;
      lo = -1;
      for (int i = 31; i >= 0; i--) if (cand[i]) lo = i;
      for (int j = SS + 1; j > 0; j--) m_samp[j] = m_samp[j-1];
      m_samp[0] = irqs;
      rise  = m_samp[SS] & ~m_samp[SS+1];
      w1c   = (strobe && rw && addr == 2'd0) ? d_in : 32'd0;
      ackm  = (m_st == 1 && irq_ack) ? (32'd1 << m_vec) : 32'd0;
      npend = (m_pend & ~w1c & ~ackm) | rise;
      nen   = (strobe && rw && addr == 2'd1) ? d_in : m_en;
      if (strobe && !rw) begin
        case (addr)
          2'd0: m_dout = m_pend;
          2'd1: m_dout = m_en;
          2'd2: m_dout = (32'(m_st) << 30) | 32'(m_vec);
          default: m_dout = 32'd0;
        endcase
      end
      case (m_st)
        0: if (lo >= 0) begin m_st = 1; m_vec = lo; end
        1: begin
          if (irq_ack) m_st = 2;
          else if (!(npend[m_vec] && nen[m_vec])) begin m_st = 0; m_vec = 0; end
        end
        default: if (strobe && rw && addr == 2'd3) begin m_st = 0; m_vec = 0; end
      endcase
      m_pend = npend;
      m_en   = nen;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("mdl_req",  32'(irq_req), 32'(m_st == 1));
      chk("mdl_vec",  32'(irq_vec), 32'(m_vec));
      chk("mdl_dout", d_out, m_dout);
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    strobe = 1'b1; rw = 1'b1; addr = a; d_in = d;
    @(negedge clk);
    strobe = 1'b0; rw = 1'b0; d_in = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] r);
    @(negedge clk);
    strobe = 1'b1; rw = 1'b0; addr = a;
    @(negedge clk);
    strobe = 1'b0;
    r = d_out;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  // Held for two captures, then enough idle edges for the request to post.
  task automatic pulse(input logic [31:0] mask);
    irqs = mask;
    repeat (2) @(negedge clk);
    irqs = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] r;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_req", 32'(irq_req), 32'd0);
    chk("rst_vec", 32'(irq_vec), 32'd0);
    chk("rst_dout", d_out, 32'd0);
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), r);
      chk($sformatf("rst_rd%0d", a), r, 32'd0);
    end

    // Single line, latency to irq_req
    bus_write(2'd1, 32'h10);
    irqs = 32'h10;
    @(posedge clk); #1 chk("lat_n0", 32'(irq_req), 32'd0);
    @(posedge clk); #1 chk("lat_n1", 32'(irq_req), 32'd0);
    @(negedge clk); irqs = '0;
    @(posedge clk); #1 chk("lat_n2", 32'(irq_req), 32'd0);
    @(posedge clk); #1 chk("lat_n3", 32'(irq_req), 32'd1);
    chk("lat_vec", 32'(irq_vec), 32'd4);
    bus_read(2'd0, r);
    chk("pend_4", r, 32'h10);

    // Ack then EOI
    ack_pulse();
    chk("ack_req", 32'(irq_req), 32'd0);
    bus_read(2'd0, r);
    chk("ack_pend", r, 32'd0);
    bus_read(2'd2, r);
    chk("svc_status", r, 32'h8000_0004);
    bus_write(2'd3, 32'd0);
    bus_read(2'd2, r);
    chk("eoi_status", r, 32'd0);

    // Priority between simultaneous arrivals
    bus_write(2'd1, 32'hFFFF_FFFF);
    pulse((32'd1 << 9) | (32'd1 << 3));
    chk("pri_req", 32'(irq_req), 32'd1);
    chk("pri_vec", 32'(irq_vec), 32'd3);
    ack_pulse();
    bus_write(2'd3, 32'd0);
    chk("b2b_idle", 32'(irq_req), 32'd0);
    @(negedge clk);
    chk("b2b_req", 32'(irq_req), 32'd1);
    chk("b2b_vec", 32'(irq_vec), 32'd9);
    ack_pulse();
    bus_write(2'd3, 32'd0);

    // Withdrawal by PENDING clear and by ENABLE clear
    pulse(32'd1 << 7);
    chk("wd1_vec", 32'(irq_vec), 32'd7);
    bus_write(2'd0, 32'h80);
    chk("wd1_req", 32'(irq_req), 32'd0);
    bus_read(2'd2, r);
    chk("wd1_status", r, 32'd0);
    pulse(32'd1 << 7);
    chk("wd2_vec", 32'(irq_vec), 32'd7);
    bus_write(2'd1, 32'd0);
    chk("wd2_req", 32'(irq_req), 32'd0);
    bus_read(2'd2, r);
    chk("wd2_status", r, 32'd0);

    // Set beats same-cycle W1C while in SERVICE
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    pulse(32'd1 << 5);
    chk("col_vec", 32'(irq_vec), 32'd5);
    ack_pulse();
    irqs = 32'h4;
    @(negedge clk);
    @(negedge clk);
    irqs = '0; strobe = 1'b1; rw = 1'b1; addr = 2'd0; d_in = 32'h4;
    @(negedge clk);
    strobe = 1'b0; rw = 1'b0; d_in = '0;
    bus_read(2'd0, r);
    chk("col_pend", r, 32'h4);
    chk("col_svc_req", 32'(irq_req), 32'd0);
    bus_write(2'd3, 32'd0);
    @(negedge clk);
    chk("col_req", 32'(irq_req), 32'd1);
    chk("col_vec2", 32'(irq_vec), 32'd2);

    // Asynchronous reset mid-request
    #1 reset_n = 1'b0;
    #1 chk("arst_req", 32'(irq_req), 32'd0);
    chk("arst_vec", 32'(irq_vec), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd1, r);
    chk("arst_en", r, 32'd0);

    // Random traffic, checked every cycle by the model
    bus_write(2'd1, 32'hFFFF_FFFF);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) irqs = irqs ^ (32'd1 << $urandom_range(31));
      strobe  = ($urandom_range(2) == 0);
      rw      = $urandom_range(1) == 1;
      addr    = 2'($urandom_range(3));
      d_in    = $urandom;
      irq_ack = ($urandom_range(3) == 0);
    end
    @(negedge clk);
    strobe = 1'b0; rw = 1'b0; irq_ack = 1'b0; irqs = '0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
